// File: rtl/sdram_arbiter.sv
// Two-master arbiter onto the SDRAM s1 port. The grant is registered one cycle after the request; commands and read returns are then combinational.
// Backpressure: s1 waitrequest passes through to the granted master, and reads also stall while the tag FIFO holds MAX_PENDING entries.
module sdram_arbiter #(
    parameter int ADDR_W      = 22,
    parameter int DATA_W      = 16,
    parameter int MAX_PENDING = 8,
    parameter int MAX_RUN     = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [ADDR_W-1:0] a_address,
    input  logic              a_read,
    input  logic              a_write,
    input  logic [DATA_W-1:0] a_writedata,
    input  logic [1:0]        a_byteenable,
    output logic              a_waitrequest,
    output logic [DATA_W-1:0] a_readdata,
    output logic              a_readdatavalid,
    input  logic [ADDR_W-1:0] b_address,
    input  logic              b_read,
    input  logic              b_write,
    input  logic [DATA_W-1:0] b_writedata,
    input  logic [1:0]        b_byteenable,
    output logic              b_waitrequest,
    output logic [DATA_W-1:0] b_readdata,
    output logic              b_readdatavalid,
    output logic [ADDR_W-1:0] sdram_s1_address,
    output logic [1:0]        sdram_s1_byteenable_n,
    output logic              sdram_s1_chipselect,
    output logic [DATA_W-1:0] sdram_s1_writedata,
    output logic              sdram_s1_read_n,
    output logic              sdram_s1_write_n,
    input  logic [DATA_W-1:0] sdram_s1_readdata,
    input  logic              sdram_s1_readdatavalid,
    input  logic              sdram_s1_waitrequest,
    output logic              rsp_err
);

    localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int RUN_W = $clog2(MAX_RUN + 1);

    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [RUN_W-1:0]       r_run_cnt;
    logic [MAX_PENDING-1:0] r_tag;
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_rsp_err;

    logic                   w_a_req;
    logic                   w_b_req;
    logic                   w_g_read;
    logic                   w_g_write;
    logic [ADDR_W-1:0]      w_g_addr;
    logic [DATA_W-1:0]      w_g_wdata;
    logic [1:0]             w_g_be;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_blocked;
    logic                   w_cs;
    logic                   w_accept;
    logic                   w_run_last;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_head;

    assign w_a_req = a_read | a_write;
    assign w_b_req = b_read | b_write;

    always_comb begin
        w_g_read  = 1'b0;
        w_g_write = 1'b0;
        w_g_addr  = '0;
        w_g_wdata = '0;
        w_g_be    = 2'b00;
        case (r_state)
            GRANT_A: begin
                w_g_read  = a_read;
                w_g_write = a_write;
                w_g_addr  = a_address;
                w_g_wdata = a_writedata;
                w_g_be    = a_byteenable;
            end
            GRANT_B: begin
                w_g_read  = b_read;
                w_g_write = b_write;
                w_g_addr  = b_address;
                w_g_wdata = b_writedata;
                w_g_be    = b_byteenable;
            end
            default: ;
        endcase
    end

    // Full check uses the registered count; a same-cycle pop does not unblock.
    assign w_full     = (r_cnt == CNT_W'(MAX_PENDING));
    assign w_empty    = (r_cnt == '0);
    assign w_blocked  = w_g_read & w_full;
    assign w_cs       = (w_g_read | w_g_write) & ~w_blocked;
    assign w_accept   = w_cs & ~sdram_s1_waitrequest;
    assign w_run_last = (r_run_cnt >= RUN_W'(MAX_RUN - 1));
    assign w_push     = w_accept & w_g_read;
    assign w_pop      = sdram_s1_readdatavalid & ~w_empty;
    assign w_head     = r_tag[r_rptr];

    assign sdram_s1_chipselect   = w_cs;
    assign sdram_s1_read_n       = ~w_g_read;
    assign sdram_s1_write_n      = ~(w_g_write & ~w_g_read);
    assign sdram_s1_byteenable_n = ~w_g_be;
    assign sdram_s1_address      = w_g_addr;
    assign sdram_s1_writedata    = w_g_wdata;

    assign a_waitrequest   = (r_state == GRANT_A) ? (sdram_s1_waitrequest | w_blocked) : 1'b1;
    assign b_waitrequest   = (r_state == GRANT_B) ? (sdram_s1_waitrequest | w_blocked) : 1'b1;
    assign a_readdata      = sdram_s1_readdata;
    assign b_readdata      = sdram_s1_readdata;
    assign a_readdatavalid = w_pop & ~w_head;
    assign b_readdatavalid = w_pop & w_head;
    assign rsp_err         = r_rsp_err;

    // A pending unaccepted command always keeps the grant, so s1 inputs stay stable.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_a_req)      w_state_nxt = GRANT_A;
                else if (w_b_req) w_state_nxt = GRANT_B;
            end
            GRANT_A: begin
                if (!w_a_req)                             w_state_nxt = w_b_req ? GRANT_B : IDLE;
                else if (w_accept && w_run_last && w_b_req) w_state_nxt = GRANT_B;
            end
            GRANT_B: begin
                if (!w_b_req)                             w_state_nxt = w_a_req ? GRANT_A : IDLE;
                else if (w_accept && w_run_last && w_a_req) w_state_nxt = GRANT_A;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state   <= IDLE;
            r_run_cnt <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_cnt     <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state)
                r_run_cnt <= '0;
            else if (w_accept && (r_run_cnt != RUN_W'(MAX_RUN)))
                r_run_cnt <= r_run_cnt + RUN_W'(1);

            if (w_push) begin
                r_tag[r_wptr] <= (r_state == GRANT_B);
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop)
                r_rptr <= r_rptr + PTR_W'(1);

            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: ;
            endcase

            if (sdram_s1_readdatavalid && w_empty)
                r_rsp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: reset, pipelined reads, tie-break, run cap, full blocking, stray beats.
module tb_sdram_arbiter;

    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic [21:0] a_address = '0;
    logic        a_read = 1'b0;
    logic        a_write = 1'b0;
    logic [15:0] a_writedata = '0;
    logic [1:0]  a_byteenable = 2'b11;
    logic        a_waitrequest;
    logic [15:0] a_readdata;
    logic        a_readdatavalid;
    logic [21:0] b_address = '0;
    logic        b_read = 1'b0;
    logic        b_write = 1'b0;
    logic [15:0] b_writedata = '0;
    logic [1:0]  b_byteenable = 2'b11;
    logic        b_waitrequest;
    logic [15:0] b_readdata;
    logic        b_readdatavalid;
    logic [21:0] sdram_s1_address;
    logic [1:0]  sdram_s1_byteenable_n;
    logic        sdram_s1_chipselect;
    logic [15:0] sdram_s1_writedata;
    logic        sdram_s1_read_n;
    logic        sdram_s1_write_n;
    logic [15:0] sdram_s1_readdata = '0;
    logic        sdram_s1_readdatavalid = 1'b0;
    logic        sdram_s1_waitrequest = 1'b0;
    logic        rsp_err;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    sdram_arbiter dut (
        .clk_clk                (clk_clk),
        .reset_reset            (reset_reset),
        .a_address              (a_address),
        .a_read                 (a_read),
        .a_write                (a_write),
        .a_writedata            (a_writedata),
        .a_byteenable           (a_byteenable),
        .a_waitrequest          (a_waitrequest),
        .a_readdata             (a_readdata),
        .a_readdatavalid        (a_readdatavalid),
        .b_address              (b_address),
        .b_read                 (b_read),
        .b_write                (b_write),
        .b_writedata            (b_writedata),
        .b_byteenable           (b_byteenable),
        .b_waitrequest          (b_waitrequest),
        .b_readdata             (b_readdata),
        .b_readdatavalid        (b_readdatavalid),
        .sdram_s1_address       (sdram_s1_address),
        .sdram_s1_byteenable_n  (sdram_s1_byteenable_n),
        .sdram_s1_chipselect    (sdram_s1_chipselect),
        .sdram_s1_writedata     (sdram_s1_writedata),
        .sdram_s1_read_n        (sdram_s1_read_n),
        .sdram_s1_write_n       (sdram_s1_write_n),
        .sdram_s1_readdata      (sdram_s1_readdata),
        .sdram_s1_readdatavalid (sdram_s1_readdatavalid),
        .sdram_s1_waitrequest   (sdram_s1_waitrequest),
        .rsp_err                (rsp_err)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Leaves the bench 1 time unit after a rising edge, where inputs are driven.
    task automatic cyc();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic issue_read(input logic m, input logic [21:0] addr);
        int n;
        if (!m) begin a_read = 1'b1; a_address = addr; end
        else    begin b_read = 1'b1; b_address = addr; end
        #1;
        n = 0;
        while ((m ? b_waitrequest : a_waitrequest) && n < 10) begin
            cyc();
            #1;
            n++;
        end
        chk1("rd_grant", m ? b_waitrequest : a_waitrequest, 1'b0);
        chk1("rd_cs", sdram_s1_chipselect, 1'b1);
        chkv("rd_addr", 32'(sdram_s1_address), 32'(addr));
        cyc();
        if (!m) a_read = 1'b0;
        else    b_read = 1'b0;
    endtask

    task automatic beat(input logic [15:0] d, input logic ea, input logic eb);
        sdram_s1_readdatavalid = 1'b1;
        sdram_s1_readdata      = d;
        #1;
        chk1("beat_a_vld", a_readdatavalid, ea);
        chk1("beat_b_vld", b_readdatavalid, eb);
        if (ea) chkv("beat_a_dat", 32'(a_readdata), 32'(d));
        if (eb) chkv("beat_b_dat", 32'(b_readdata), 32'(d));
        cyc();
        sdram_s1_readdatavalid = 1'b0;
    endtask

    initial begin
        logic [15:0] d;

        // Reset values
        cyc();
        cyc();
        #1;
        chk1("rst_cs", sdram_s1_chipselect, 1'b0);
        chk1("rst_read_n", sdram_s1_read_n, 1'b1);
        chk1("rst_write_n", sdram_s1_write_n, 1'b1);
        chkv("rst_be_n", 32'(sdram_s1_byteenable_n), 32'h3);
        chkv("rst_addr", 32'(sdram_s1_address), 32'h0);
        chkv("rst_wdata", 32'(sdram_s1_writedata), 32'h0);
        chk1("rst_a_wait", a_waitrequest, 1'b1);
        chk1("rst_b_wait", b_waitrequest, 1'b1);
        chk1("rst_a_rdv", a_readdatavalid, 1'b0);
        chk1("rst_b_rdv", b_readdatavalid, 1'b0);
        chk1("rst_err", rsp_err, 1'b0);

        // Four back-to-back A reads, data returning 3 cycles after each accept
        cyc();
        reset_reset = 1'b0;
        a_read = 1'b1;
        a_address = 22'h100;
        #1;
        chk1("t1_idle_wait", a_waitrequest, 1'b1);
        chk1("t1_idle_cs", sdram_s1_chipselect, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            a_read = (i < 4);
            a_address = 22'h100 + 22'(i);
            sdram_s1_readdatavalid = (i >= 3 && i <= 6);
            d = 16'(16'h1111 * (i - 2));
            sdram_s1_readdata = d;
            #1;
            if (i < 4) begin
                chk1("t1_cs", sdram_s1_chipselect, 1'b1);
                chk1("t1_read_n", sdram_s1_read_n, 1'b0);
                chk1("t1_a_wait", a_waitrequest, 1'b0);
                chkv("t1_addr", 32'(sdram_s1_address), 32'h100 + 32'(i));
                chkv("t1_be_n", 32'(sdram_s1_byteenable_n), 32'h0);
            end
            chk1("t1_a_rdv", a_readdatavalid, (i >= 3 && i <= 6));
            chk1("t1_b_rdv", b_readdatavalid, 1'b0);
            if (i >= 3 && i <= 6) chkv("t1_a_data", 32'(a_readdata), 32'(d));
        end
        cyc();
        sdram_s1_readdatavalid = 1'b0;
        cyc();

        // Simultaneous request from IDLE: A wins, B waits until A drops
        a_read = 1'b1; a_address = 22'h200;
        b_read = 1'b1; b_address = 22'h300;
        #1;
        chk1("tie_idle_a", a_waitrequest, 1'b1);
        chk1("tie_idle_b", b_waitrequest, 1'b1);
        cyc();
        #1;
        chk1("tie_a_grant", a_waitrequest, 1'b0);
        chk1("tie_b_wait", b_waitrequest, 1'b1);
        chkv("tie_addr", 32'(sdram_s1_address), 32'h200);
        cyc();
        a_read = 1'b0;
        #1;
        chk1("tie_b_still_wait", b_waitrequest, 1'b1);
        chk1("tie_gap_cs", sdram_s1_chipselect, 1'b0);
        cyc();
        #1;
        chk1("tie_b_grant", b_waitrequest, 1'b0);
        chkv("tie_b_addr", 32'(sdram_s1_address), 32'h300);
        cyc();
        b_read = 1'b0;
        beat(16'hAAAA, 1'b1, 1'b0);
        beat(16'hBBBB, 1'b0, 1'b1);
        cyc();

        // Interleaved A,B,A,B reads, all outstanding before data returns
        issue_read(1'b0, 22'h400);
        issue_read(1'b1, 22'h500);
        issue_read(1'b0, 22'h401);
        issue_read(1'b1, 22'h501);
        beat(16'hC001, 1'b1, 1'b0);
        beat(16'hC002, 1'b0, 1'b1);
        beat(16'hC003, 1'b1, 1'b0);
        beat(16'hC004, 1'b0, 1'b1);
        // FIFO is empty again: an extra beat is stray
        beat(16'h0BAD, 1'b0, 1'b0);
        #1;
        chk1("stray_err", rsp_err, 1'b1);
        cyc();
        reset_reset = 1'b1;
        cyc();
        reset_reset = 1'b0;
        #1;
        chk1("stray_err_cleared", rsp_err, 1'b0);
        cyc();
        cyc();

        // Run cap: A streams writes while B holds one write
        a_write = 1'b1; a_address = 22'h10; a_writedata = 16'h5555; a_byteenable = 2'b11;
        b_write = 1'b1; b_address = 22'h3FFFFF; b_writedata = 16'hBEEF; b_byteenable = 2'b01;
        #1;
        chk1("run_idle_wait", a_waitrequest, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cyc();
            #1;
            chk1("run_a_grant", a_waitrequest, 1'b0);
            chk1("run_b_wait", b_waitrequest, 1'b1);
            chk1("run_write_n", sdram_s1_write_n, 1'b0);
        end
        cyc();
        #1;
        chk1("run_b_grant", b_waitrequest, 1'b0);
        chk1("run_a_wait", a_waitrequest, 1'b1);
        chkv("run_b_be_n", 32'(sdram_s1_byteenable_n), 32'h2);
        chkv("run_b_addr", 32'(sdram_s1_address), 32'h3FFFFF);
        chkv("run_b_wdata", 32'(sdram_s1_writedata), 32'hBEEF);
        chk1("run_b_write_n", sdram_s1_write_n, 1'b0);
        cyc();
        b_write = 1'b0;
        #1;
        chk1("run_handback_wait", a_waitrequest, 1'b1);
        cyc();
        #1;
        chk1("run_a_resume", a_waitrequest, 1'b0);
        cyc();
        a_write = 1'b0;
        cyc();
        cyc();

        // Tag FIFO full: 8 reads accepted, 9th blocked until a beat frees a slot
        a_read = 1'b1; a_address = 22'h600;
        #1;
        chk1("full_idle_wait", a_waitrequest, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc();
            #1;
            chk1("full_accept_wait", a_waitrequest, 1'b0);
            chk1("full_accept_cs", sdram_s1_chipselect, 1'b1);
        end
        cyc();
        #1;
        chk1("full_blk_wait", a_waitrequest, 1'b1);
        chk1("full_blk_cs", sdram_s1_chipselect, 1'b0);
        cyc();
        sdram_s1_readdatavalid = 1'b1;
        sdram_s1_readdata = 16'h7777;
        #1;
        chk1("full_pop_still_blk", a_waitrequest, 1'b1);
        chk1("full_pop_cs", sdram_s1_chipselect, 1'b0);
        chk1("full_pop_a_rdv", a_readdatavalid, 1'b1);
        cyc();
        sdram_s1_readdatavalid = 1'b0;
        #1;
        chk1("full_9th_wait", a_waitrequest, 1'b0);
        chk1("full_9th_cs", sdram_s1_chipselect, 1'b1);
        cyc();
        a_read = 1'b0;
        a_write = 1'b1;
        #1;
        chk1("full_wr_cs", sdram_s1_chipselect, 1'b1);
        chk1("full_wr_wait", a_waitrequest, 1'b0);
        chk1("full_wr_write_n", sdram_s1_write_n, 1'b0);
        cyc();
        a_write = 1'b0;

        // Reset with reads pending discards tags; next beat is stray
        cyc();
        reset_reset = 1'b1;
        cyc();
        reset_reset = 1'b0;
        beat(16'h9999, 1'b0, 1'b0);
        #1;
        chk1("rstpend_err", rsp_err, 1'b1);
        cyc();
        cyc();
        cyc();
        #1;
        chk1("rstpend_err_sticky", rsp_err, 1'b1);
        cyc();
        reset_reset = 1'b1;
        cyc();
        reset_reset = 1'b0;
        #1;
        chk1("rstpend_err_cleared", rsp_err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
